// File: rtl/piso_shifter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : piso_pkg                                                     |
// | Description : Shared state encoding for the piso_shifter transmitter.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package piso_pkg;

  // PARITY is always part of the encoding so the state width is identical
  // whether or not the parity option is built in.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } piso_state_t;

  // Width of the bit counter for a given word width (at least one bit).
  function automatic int count_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shifter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : piso_shifter_if                                              |
// | Description : Load/ready handshake plus serial outputs of piso_shifter.    |
// |               master = producer/observer side, slave = the shifter.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface piso_shifter_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             shift_en;
  logic             ready;
  logic             serial_out;
  logic             bit_valid;
  logic             done;

  modport master (
    output load, data_in, shift_en,
    input  ready, serial_out, bit_valid, done
  );

  modport slave (
    input  load, data_in, shift_en,
    output ready, serial_out, bit_valid, done
  );
endinterface
`default_nettype wire

// File: rtl/piso_shifter_bit_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : piso_bit_counter                                             |
// | Description : Clear/increment bit counter for piso_shifter with a          |
// |               terminal-count flag (count == WIDTH-1). Saturates at the     |
// |               terminal value and never wraps.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clock,
  input  logic reset,     // asynchronous, active-low
  input  logic clear,
  input  logic incr,
  output logic terminal
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  assign terminal = (count == LAST);

  // Count enabled shifts; hold at the terminal value so the count stays in range.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/piso_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : piso_shifter                                                 |
// | Description : Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word |
// |               on load && ready, emits one bit per shift_en cycle on        |
// |               serial_out with bit_valid, then pulses done for one cycle.   |
// |               Optional macro PISO_PARITY_EN appends an even-parity bit.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module piso_shifter
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic          clock,
  input  logic          reset,   // asynchronous, active-low
  piso_shifter_if.slave bus
);

  piso_state_t      state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic             serial_q;
  logic             bit_valid_q;
  logic             done_q;
  logic             accept;
  logic             advance;
  logic             terminal;

  // Bit that goes out first from a given register image.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  // Register image after one bit has been consumed.
  always_comb begin
    shifted = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
  end

  assign accept  = (state == IDLE)  && bus.load;
  assign advance = (state == SHIFT) && bus.shift_en;

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (accept),
    .incr     (advance),
    .terminal (terminal)
  );

  // ready is the only combinational output: a plain decode of IDLE.
  assign bus.ready      = (state == IDLE);
  assign bus.serial_out = serial_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.done       = done_q;

`ifdef PISO_PARITY_EN
  logic parity_q;

  // Even parity of the word, captured together with the word itself.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^bus.data_in;
    end
  end
`endif

  // Transfer FSM with registered serial_out / bit_valid / done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      serial_q    <= 1'b0;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.load) begin
            shift_reg   <= bus.data_in;
            serial_q    <= head_bit(bus.data_in);
            bit_valid_q <= 1'b1;
            state       <= SHIFT;
          end
        end

        SHIFT: begin
          // shift_en low leaves everything untouched: the current bit is held.
          if (bus.shift_en) begin
            shift_reg <= shifted;
            if (terminal) begin
`ifdef PISO_PARITY_EN
              serial_q    <= parity_q;
              bit_valid_q <= 1'b1;
              state       <= PARITY;
`else
              serial_q    <= 1'b0;
              bit_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state       <= DONE;
`endif
            end else begin
              serial_q <= head_bit(shifted);
            end
          end
        end

`ifdef PISO_PARITY_EN
        PARITY: begin
          if (bus.shift_en) begin
            serial_q    <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state       <= DONE;
          end
        end
`endif

        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          serial_q    <= 1'b0;
          bit_valid_q <= 1'b0;
          done_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_piso_shifter                                              |
// | Description : Self-checking bench for piso_shifter. Two instances (LSB-    |
// |               first and MSB-first) share clock and reset; a select flag    |
// |               routes stimulus to one and observation from it. Expected     |
// |               bits come from a queue built from the word and bit order.    |
// |               Honours PISO_PARITY_EN for the appended parity bit.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_piso_shifter;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int SEQ_LEN = W + 1;
`else
  localparam int SEQ_LEN = W;
`endif

  logic clock;
  logic reset;
  logic sel;          // 0: LSB-first instance, 1: MSB-first instance
  logic load;
  logic [W-1:0] data_in;
  logic shift_en;

  int compared   = 0;
  int mismatched = 0;

  piso_shifter_if #(.WIDTH(W)) l_if ();
  piso_shifter_if #(.WIDTH(W)) m_if ();

  assign l_if.load     = load & ~sel;
  assign m_if.load     = load & sel;
  assign l_if.data_in  = data_in;
  assign m_if.data_in  = data_in;
  assign l_if.shift_en = shift_en;
  assign m_if.shift_en = shift_en;

  piso_shifter #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clock (clock),
    .reset (reset),
    .bus   (l_if)
  );

  piso_shifter #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clock (clock),
    .reset (reset),
    .bus   (m_if)
  );

  logic obs_ready, obs_done, obs_bv, obs_so;
  assign obs_ready = sel ? m_if.ready      : l_if.ready;
  assign obs_done  = sel ? m_if.done       : l_if.done;
  assign obs_bv    = sel ? m_if.bit_valid  : l_if.bit_valid;
  assign obs_so    = sel ? m_if.serial_out : l_if.serial_out;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Send one word on the selected instance and check every cycle against the
  // expected bit queue. mode 0: shift_en always 1; 1: random shift_en;
  // 2: three stall cycles while bit index 2 is on the line.
  // Called and returns at a negedge.
  task automatic run_word(input logic [W-1:0] word, input int mode, input bit hold,
                          input logic [W-1:0] next_data,
                          output int valid_cycles, output int done_cycle);
    bit q[$];
    int n, idx, k, stalls;
    bit finished, en;
    logic [3:0] obs, exp;
    q = {};
    for (int i = 0; i < W; i++) q.push_back(sel ? word[W-1-i] : word[i]);
`ifdef PISO_PARITY_EN
    q.push_back(^word);
`endif
    valid_cycles = 0;
    done_cycle   = 0;
    n = 0;
    while (obs_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    compared++;
    if (obs_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL ready_wait: ready=%b required 1", obs_ready);
      return;
    end
    load     = 1'b1;
    data_in  = word;
    shift_en = 1'($urandom);
    @(posedge clock);
    #1;
    load    = hold;
    data_in = hold ? next_data : W'($urandom);
    idx = 0; k = 0; stalls = 0; finished = 0;
    while (!finished && k < 100) begin
      @(negedge clock);
      k++;
      obs = {obs_ready, obs_done, obs_bv, obs_so};
      if (idx < q.size()) exp = {1'b0, 1'b0, 1'b1, q[idx]};
      else                exp = 4'b0100;
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL cycle_%0d {ready,done,bit_valid,serial}: got %b required %b (bit idx %0d)",
                 k, obs, exp, idx);
      end
      if (idx < q.size()) begin
        valid_cycles++;
        case (mode)
          0:       en = 1'b1;
          1:       en = ($urandom_range(0, 3) != 0);
          default: begin
            en = !(idx == 2 && stalls < 3);
            if (!en) stalls++;
          end
        endcase
        shift_en = en;
        if (en) idx++;
        if (!hold) begin
          load    = 1'($urandom);
          data_in = W'($urandom);
        end
      end else begin
        finished   = 1;
        done_cycle = k;
        load       = hold;
        shift_en   = 1'($urandom);
      end
    end
    compared++;
    if (!finished) begin
      mismatched++;
      $display("FAIL done_timeout: no done within %0d cycles", k);
      return;
    end
    // The cycle after done must be IDLE.
    @(negedge clock);
    obs = {obs_ready, obs_done, obs_bv, obs_so};
    compared++;
    if (obs !== 4'b1000) begin
      mismatched++;
      $display("FAIL idle_after_done: got %b required 1000", obs);
    end
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    sel = 0; load = 0; data_in = '0; shift_en = 0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    obs = {l_if.ready, l_if.done, l_if.bit_valid, l_if.serial_out};
    compared++;
    if (obs !== 4'b1000) begin
      mismatched++;
      $display("FAIL reset_lsb: got %b required 1000", obs);
    end
    obs = {m_if.ready, m_if.done, m_if.bit_valid, m_if.serial_out};
    compared++;
    if (obs !== 4'b1000) begin
      mismatched++;
      $display("FAIL reset_msb: got %b required 1000", obs);
    end
    reset = 1'b1;
    @(negedge clock);
    obs = {obs_ready, obs_done, obs_bv, obs_so};
    compared++;
    if (obs !== 4'b1000) begin
      mismatched++;
      $display("FAIL after_release: got %b required 1000", obs);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] obs;
    logic [W-1:0] word;
    word = 8'hA5;
    sel = 0; shift_en = 1; load = 1; data_in = word;
    @(posedge clock);
    #1 load = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    compared++;
    if ({obs_bv, obs_so} !== {1'b1, word[3]}) begin
      mismatched++;
      $display("FAIL mid_word_bit3: got %b required %b", {obs_bv, obs_so}, {1'b1, word[3]});
    end
    #2 reset = 1'b0;
    #1;
    obs = {obs_ready, obs_done, obs_bv, obs_so};
    compared++;
    if (obs !== 4'b1000) begin
      mismatched++;
      $display("FAIL async_reset_immediate: got %b required 1000", obs);
    end
    repeat (2) begin
      @(negedge clock);
      obs = {obs_ready, obs_done, obs_bv, obs_so};
      compared++;
      if (obs !== 4'b1000) begin
        mismatched++;
        $display("FAIL reset_held: got %b required 1000", obs);
      end
    end
    reset = 1'b1;
    @(negedge clock);
    obs = {obs_ready, obs_done, obs_bv, obs_so};
    compared++;
    if (obs !== 4'b1000) begin
      mismatched++;
      $display("FAIL reset_mid_release: got %b required 1000", obs);
    end
  endtask

  task automatic test_lsb_first();
    int vc, dc;
    sel = 0;
    run_word(8'hA5, 0, 0, 8'h00, vc, dc);
    compared++;
    if (dc !== SEQ_LEN + 1) begin
      mismatched++;
      $display("FAIL lsb_done_latency: got %0d required %0d", dc, SEQ_LEN + 1);
    end
  endtask

  task automatic test_msb_first();
    int vc, dc;
    sel = 1;
    run_word(8'h81, 0, 0, 8'h00, vc, dc);
    compared++;
    if (dc !== SEQ_LEN + 1) begin
      mismatched++;
      $display("FAIL msb_done_latency: got %0d required %0d", dc, SEQ_LEN + 1);
    end
    sel = 0;
  endtask

  task automatic test_stall();
    int vc, dc;
    sel = 0;
    run_word(8'h3C, 2, 0, 8'h00, vc, dc);
    compared++;
    if (vc !== SEQ_LEN + 3) begin
      mismatched++;
      $display("FAIL stall_valid_cycles: got %0d required %0d", vc, SEQ_LEN + 3);
    end
  endtask

  task automatic test_back_to_back();
    int vc, dc;
    sel = 0;
    run_word(8'h11, 0, 1, 8'h22, vc, dc);
    run_word(8'h22, 0, 0, 8'h00, vc, dc);
    compared++;
    if (dc !== SEQ_LEN + 1) begin
      mismatched++;
      $display("FAIL back_to_back_latency: got %0d required %0d", dc, SEQ_LEN + 1);
    end
  endtask

  task automatic test_parity();
    int vc, dc;
    sel = 0;
    run_word(8'h07, 0, 0, 8'h00, vc, dc);
    compared++;
    if (vc !== SEQ_LEN) begin
      mismatched++;
      $display("FAIL parity_valid_cycles: got %0d required %0d", vc, SEQ_LEN);
    end
  endtask

  task automatic test_random();
    int vc, dc;
    for (int i = 0; i < 12; i++) begin
      sel = (i >= 8);
      run_word(W'($urandom), 1, 0, 8'h00, vc, dc);
    end
    sel = 0;
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_reset_mid_word();
    test_lsb_first();
    test_msb_first();
    test_stall();
    test_back_to_back();
    test_parity();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
